// File: rtl/lc3_ir_field_stage.sv
// lc3_ir_field_stage: LC-3 IR stage with 2-entry skid buffer, raw field slices and retired-word counter.
// Optional LC3_IR_ILLEGAL_EN flags the reserved opcode 4'b1101 on the head word.
module lc3_ir_field_stage #(
    parameter logic [15:0] IR_RST = 16'h0000,
    parameter int          CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [15:0]      mem_data,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [15:0]      ir,
    output logic [3:0]       opcode,
    output logic [2:0]       dr,
    output logic [2:0]       sr1,
    output logic [2:0]       sr2,
    output logic             imm_flag,
    output logic [4:0]       imm5,
    output logic [5:0]       offset6,
    output logic [8:0]       pcoff9,
    output logic [10:0]      pcoff11,
    output logic [7:0]       trapvect8,
    output logic [CNT_W-1:0] inst_count,
    output logic             illegal
);
    logic             r_head_valid;
    logic             r_skid_valid;
    logic [15:0]      r_head;
    logic [15:0]      r_skid;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_pop;

    // mem_ready depends only on registered state, flush and rst, never on the handshake inputs
    assign mem_ready = !r_skid_valid && !flush && !rst;
    assign dec_valid = r_head_valid;
    assign w_accept  = mem_valid && mem_ready;
    assign w_pop     = r_head_valid && dec_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_head       <= IR_RST;
            r_skid       <= 16'h0000;
            r_count      <= '0;
        end else begin
            if (w_pop)
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (flush) begin
                r_head_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_head       <= IR_RST;
            end else if (!r_head_valid) begin
                if (w_accept) begin
                    r_head_valid <= 1'b1;
                    r_head       <= mem_data;
                end
            end else if (!r_skid_valid) begin
                if (w_accept && !w_pop) begin
                    r_skid_valid <= 1'b1;
                    r_skid       <= mem_data;
                end else if (w_accept) begin
                    r_head <= mem_data;
                end else if (w_pop) begin
                    r_head_valid <= 1'b0;
                end
            end else if (w_pop) begin
                r_head       <= r_skid;
                r_skid_valid <= 1'b0;
            end
        end
    end

    assign ir         = r_head;
    assign inst_count = r_count;
    assign opcode     = r_head[15:12];
    assign dr         = r_head[11:9];
    assign sr1        = r_head[8:6];
    assign sr2        = r_head[2:0];
    assign imm_flag   = r_head[5];
    assign imm5       = r_head[4:0];
    assign offset6    = r_head[5:0];
    assign pcoff9     = r_head[8:0];
    assign pcoff11    = r_head[10:0];
    assign trapvect8  = r_head[7:0];

`ifdef LC3_IR_ILLEGAL_EN
    assign illegal = r_head_valid && (r_head[15:12] == 4'b1101);
`else
    assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_lc3_ir_field_stage.sv
// tb_lc3_ir_field_stage: scoreboard bench for lc3_ir_field_stage (CNT_W=4 to exercise counter wrap).
module tb_lc3_ir_field_stage;
    logic        clk = 1'b0;
    logic        rst, flush, mem_valid, mem_ready, dec_valid, dec_ready, imm_flag, illegal;
    logic [15:0] mem_data, ir;
    logic [3:0]  opcode, inst_count;
    logic [2:0]  dr, sr1, sr2;
    logic [4:0]  imm5;
    logic [5:0]  offset6;
    logic [8:0]  pcoff9;
    logic [10:0] pcoff11;
    logic [7:0]  trapvect8;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic [15:0] exp_q[$];
    logic exp_ill;

    lc3_ir_field_stage #(.IR_RST(16'h0000), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_data(mem_data), .dec_valid(dec_valid), .dec_ready(dec_ready), .ir(ir),
        .opcode(opcode), .dr(dr), .sr1(sr1), .sr2(sr2), .imm_flag(imm_flag), .imm5(imm5),
        .offset6(offset6), .pcoff9(pcoff9), .pcoff11(pcoff11), .trapvect8(trapvect8),
        .inst_count(inst_count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every pop must match the oldest word the driver saw accepted.
    always @(negedge clk) begin
        if (!rst && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {48'h0, ir}, 64'hDEAD);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("pop_ir", {48'h0, ir}, {48'h0, e});
                check("pop_fields",
                      {11'h0, opcode, dr, sr1, sr2, imm_flag, imm5, offset6, pcoff9, pcoff11, trapvect8},
                      {11'h0, e[15:12], e[11:9], e[8:6], e[2:0], e[5], e[4:0], e[5:0], e[8:0], e[10:0], e[7:0]});
            end
            exp_cnt++;
        end
    end

    task automatic send(input logic [15:0] w);
        mem_valid = 1'b1;
        mem_data  = w;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                exp_q.push_back(w);
                @(posedge clk); #1;
                mem_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 64'h1, 64'h0);
        mem_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef LC3_IR_ILLEGAL_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        rst = 1'b1; flush = 1'b0; mem_valid = 1'b0; mem_data = 16'h0; dec_ready = 1'b0;
        #2;
        check("rst_dec_valid", {63'h0, dec_valid}, 64'h0);
        check("rst_mem_ready", {63'h0, mem_ready}, 64'h0);
        check("rst_ir", {48'h0, ir}, 64'h0);
        check("rst_count", {60'h0, inst_count}, 64'h0);
        check("rst_illegal", {63'h0, illegal}, 64'h0);
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("rel_mem_ready", {63'h0, mem_ready}, 64'h1);
        step(1);

        dec_ready = 1'b1;
        send(16'h6A7F);
        check("lat_dec_valid", {63'h0, dec_valid}, 64'h1);
        check("lat_ir", {48'h0, ir}, 64'h6A7F);
        check("offset6", {58'h0, offset6}, 64'h3F);
        send(16'h1261);
        check("imm5", {59'h0, imm5}, 64'h01);
        send(16'hF025);
        check("trapvect8", {56'h0, trapvect8}, 64'h25);
        step(1);
        check("stream_count", {60'h0, inst_count}, 64'd3);
        check("stream_empty", {63'h0, dec_valid}, 64'h0);
        check("keep_ir", {48'h0, ir}, 64'hF025);

        dec_ready = 1'b0;
        send(16'h2001);
        send(16'h3002);
        check("bp_mem_ready", {63'h0, mem_ready}, 64'h0);
        check("bp_ir", {48'h0, ir}, 64'h2001);
        step(2);
        check("bp_hold_ir", {48'h0, ir}, 64'h2001);
        check("bp_hold_pcoff9", {55'h0, pcoff9}, 64'h001);
        dec_ready = 1'b1;
        step(2);
        dec_ready = 1'b0;
        check("bp_mem_ready_back", {63'h0, mem_ready}, 64'h1);
        check("bp_count", {60'h0, inst_count}, 64'd5);
        check("bp_drained", {63'h0, dec_valid}, 64'h0);

        send(16'h5020);
        send(16'h5021);
        mem_valid = 1'b1; mem_data = 16'h0E05; flush = 1'b1;
        @(negedge clk);
        check("flush_mem_ready", {63'h0, mem_ready}, 64'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        check("flush_dec_valid", {63'h0, dec_valid}, 64'h0);
        check("flush_ir", {48'h0, ir}, 64'h0);
        send(16'h0E05);
        check("resent_ir", {48'h0, ir}, 64'h0E05);
        dec_ready = 1'b1;
        step(1);
        dec_ready = 1'b0;
        check("flush_count", {60'h0, inst_count}, 64'd6);

        send(16'hD000);
        check("illegal_head", {63'h0, illegal}, {63'h0, exp_ill});
        dec_ready = 1'b1;
        step(1);
        check("illegal_after_pop", {63'h0, illegal}, 64'h0);
        for (int i = 0; i < 10; i++) send(16'h1000 + 16'(i));
        step(1);
        check("wrap_count", {60'h0, inst_count}, 64'd1);
        check("model_count", {60'h0, inst_count}, {60'h0, 4'(exp_cnt)});

        dec_ready = 1'b0;
        send(16'h4ABC);
        rst = 1'b1;
        #1;
        check("midrst_dec_valid", {63'h0, dec_valid}, 64'h0);
        check("midrst_mem_ready", {63'h0, mem_ready}, 64'h0);
        check("midrst_ir", {48'h0, ir}, 64'h0);
        exp_q.delete();
        step(1);
        rst = 1'b0;
        step(1);
        check("midrst_count", {60'h0, inst_count}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
